// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer for the rv32i fetch front end
//
// Holds the architectural PC and offers it to fetch over a valid/ready
// handshake. After each fetch handshake exactly one update command is
// accepted (Incr, Jump, Branch, Trap) before the next PC is offered.
//
// Ports:
//   clk, rstn             clock (rising edge), asynchronous active-low reset
//   i_incr_valid/o_incr_ready/i_incr_op/i_incr_data/i_incr_compressed
//                         PC-update command channel
//   i_trap_base           trap handler address (low two bits ignored)
//   o_pc_valid/i_pc_ready/o_pc_data
//                         PC issue channel towards fetch
//   o_epc                 PC of the last trapping instruction
//   o_exc_valid/o_exc_tval
//                         misaligned-target exception pulse and offending address

module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              SUPPORT_C    = 1'b0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_incr_valid,
    output logic            o_incr_ready,
    input  logic [1:0]      i_incr_op,
    input  logic [XLEN-1:0] i_incr_data,
    input  logic            i_incr_compressed,
    input  logic [XLEN-1:0] i_trap_base,
    output logic            o_pc_valid,
    input  logic            i_pc_ready,
    output logic [XLEN-1:0] o_pc_data,
    output logic [XLEN-1:0] o_epc,
    output logic            o_exc_valid,
    output logic [XLEN-1:0] o_exc_tval
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_AWAIT = 2'd2
    } state_t;

    localparam logic [1:0] OP_INCR   = 2'd0;
    localparam logic [1:0] OP_JUMP   = 2'd1;
    localparam logic [1:0] OP_BRANCH = 2'd2;
    localparam logic [1:0] OP_TRAP   = 2'd3;

    localparam logic [XLEN-1:0] STEP_FULL  = XLEN'(4);
    localparam logic [XLEN-1:0] STEP_HALF  = XLEN'(2);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            exc_q, exc_d;
    logic            pc_valid_q;
    logic            incr_ready_q;

    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] seq_step;
    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] cf_target;
    logic            cf_misaligned;

    // Datapath candidates are computed unconditionally; the FSM only picks one.
    always_comb begin
        trap_target = i_trap_base & ALIGN_MASK;
        seq_step    = (SUPPORT_C && i_incr_compressed) ? STEP_HALF : STEP_FULL;
        seq_target  = pc_q + seq_step;
        cf_target   = (i_incr_op == OP_JUMP) ? i_incr_data : (pc_q + i_incr_data);
        // With compressed support only bit 0 matters; otherwise both low bits.
        cf_misaligned = SUPPORT_C ? cf_target[0] : (cf_target[1:0] != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        tval_d  = tval_q;
        exc_d   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (i_pc_ready) begin
                    state_d = ST_AWAIT;
                end
            end
            ST_AWAIT: begin
                if (i_incr_valid) begin
                    state_d = ST_ISSUE;
                    case (i_incr_op)
                        OP_INCR: begin
                            pc_d = seq_target;
                        end
                        OP_TRAP: begin
                            pc_d  = trap_target;
                            epc_d = pc_q;
                        end
                        default: begin
                            // Jump and Branch: a misaligned target redirects to
                            // the trap handler instead of being taken.
                            if (cf_misaligned) begin
                                pc_d   = trap_target;
                                epc_d  = pc_q;
                                tval_d = cf_target;
                                exc_d  = 1'b1;
                            end else begin
                                pc_d = cf_target;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            tval_q       <= '0;
            exc_q        <= 1'b0;
            pc_valid_q   <= 1'b0;
            incr_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            tval_q       <= tval_d;
            exc_q        <= exc_d;
            // Handshake flags are registered from the next state so they are
            // flop outputs that always agree with the state register.
            pc_valid_q   <= (state_d == ST_ISSUE);
            incr_ready_q <= (state_d == ST_AWAIT);
        end
    end

    assign o_pc_valid   = pc_valid_q;
    assign o_incr_ready = incr_ready_q;
    assign o_pc_data    = pc_q;
    assign o_epc        = epc_q;
    assign o_exc_valid  = exc_q;
    assign o_exc_tval   = tval_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer (SUPPORT_C=0 and 1 in lockstep)

module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        incr_valid = 1'b0;
    logic [1:0]  incr_op = 2'd0;
    logic [31:0] incr_data = '0;
    logic        incr_comp = 1'b0;
    logic [31:0] trap_base = '0;
    logic        pc_ready = 1'b0;

    logic [1:0]       incr_ready;
    logic [1:0]       pc_valid;
    logic [1:0]       exc_valid;
    logic [1:0][31:0] pc_data;
    logic [1:0][31:0] epc;
    logic [1:0][31:0] tval;

    // Reference model, one entry per instance (0: no C, 1: with C)
    logic [31:0] m_pc   [2];
    logic [31:0] m_epc  [2];
    logic [31:0] m_tval [2];
    logic        m_exc  [2];

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .SUPPORT_C(1'b0)) dut0 (
        .clk(clk), .rstn(rstn),
        .i_incr_valid(incr_valid), .o_incr_ready(incr_ready[0]),
        .i_incr_op(incr_op), .i_incr_data(incr_data),
        .i_incr_compressed(incr_comp), .i_trap_base(trap_base),
        .o_pc_valid(pc_valid[0]), .i_pc_ready(pc_ready),
        .o_pc_data(pc_data[0]), .o_epc(epc[0]),
        .o_exc_valid(exc_valid[0]), .o_exc_tval(tval[0])
    );

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .SUPPORT_C(1'b1)) dut1 (
        .clk(clk), .rstn(rstn),
        .i_incr_valid(incr_valid), .o_incr_ready(incr_ready[1]),
        .i_incr_op(incr_op), .i_incr_data(incr_data),
        .i_incr_compressed(incr_comp), .i_trap_base(trap_base),
        .o_pc_valid(pc_valid[1]), .i_pc_ready(pc_ready),
        .o_pc_data(pc_data[1]), .o_epc(epc[1]),
        .o_exc_valid(exc_valid[1]), .o_exc_tval(tval[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset();
        for (int ci = 0; ci < 2; ci++) begin
            m_pc[ci]   = RV;
            m_epc[ci]  = '0;
            m_tval[ci] = '0;
            m_exc[ci]  = 1'b0;
        end
    endtask

    task automatic mdl_apply(input logic [1:0] op, input logic [31:0] d,
                             input logic comp, input logic [31:0] base);
        logic [31:0] tgt;
        logic [31:0] abase;
        int unsigned align;
        abase = base - (base % 4);
        for (int ci = 0; ci < 2; ci++) begin
            align = (ci == 1) ? 2 : 4;
            m_exc[ci] = 1'b0;
            if (op == 2'd0) begin
                m_pc[ci] = m_pc[ci] + ((ci == 1 && comp) ? 32'd2 : 32'd4);
            end else if (op == 2'd3) begin
                m_epc[ci] = m_pc[ci];
                m_pc[ci]  = abase;
            end else begin
                tgt = (op == 2'd1) ? d : (m_pc[ci] + d);
                if ((tgt % align) != 0) begin
                    m_epc[ci]  = m_pc[ci];
                    m_tval[ci] = tgt;
                    m_pc[ci]   = abase;
                    m_exc[ci]  = 1'b1;
                end else begin
                    m_pc[ci] = tgt;
                end
            end
        end
    endtask

    task automatic check_all(input string tag, input logic exp_valid, input logic exp_ready);
        for (int ci = 0; ci < 2; ci++) begin
            chk($sformatf("%s.c%0d.pc_valid", tag, ci), 32'(pc_valid[ci]), 32'(exp_valid));
            chk($sformatf("%s.c%0d.incr_ready", tag, ci), 32'(incr_ready[ci]), 32'(exp_ready));
            chk($sformatf("%s.c%0d.pc_data", tag, ci), pc_data[ci], m_pc[ci]);
            chk($sformatf("%s.c%0d.epc", tag, ci), epc[ci], m_epc[ci]);
            chk($sformatf("%s.c%0d.tval", tag, ci), tval[ci], m_tval[ci]);
            chk($sformatf("%s.c%0d.exc_valid", tag, ci), 32'(exc_valid[ci]), 32'(m_exc[ci]));
        end
    endtask

    // Entered with both DUTs in ISSUE; leaves them in ISSUE with the new PC.
    // During the ISSUE stall, junk commands are presented and must be ignored.
    task automatic do_update(input string tag, input logic [1:0] op, input logic [31:0] d,
                             input logic comp, input logic [31:0] base,
                             input int issue_wait, input int await_wait);
        for (int i = 0; i < issue_wait; i++) begin
            incr_valid = 1'($urandom);
            incr_op    = 2'($urandom);
            incr_data  = $urandom;
            tick();
            check_all({tag, ".stall"}, 1'b1, 1'b0);
        end
        pc_ready   = 1'b1;
        tick();
        pc_ready   = 1'b0;
        incr_valid = 1'b0;
        check_all({tag, ".await"}, 1'b0, 1'b1);
        for (int i = 0; i < await_wait; i++) begin
            tick();
            check_all({tag, ".idle"}, 1'b0, 1'b1);
        end
        incr_valid = 1'b1;
        incr_op    = op;
        incr_data  = d;
        incr_comp  = comp;
        trap_base  = base;
        tick();
        incr_valid = 1'b0;
        mdl_apply(op, d, comp, base);
        check_all({tag, ".upd"}, 1'b1, 1'b0);
        m_exc[0] = 1'b0;
        m_exc[1] = 1'b0;
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_data;

        mdl_reset();
        #12;
        check_all("reset", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check_all("boot", 1'b0, 1'b0);
        tick();
        check_all("first_issue", 1'b1, 1'b0);
        chk("first_pc", pc_data[0], 32'h0000_0100);

        // Five sequential steps from the reset vector
        for (int i = 0; i < 5; i++) begin
            do_update("incr", 2'd0, 32'h0, 1'b0, 32'h0, 0, 0);
        end
        chk("incr5_pc", pc_data[0], 32'h0000_0114);

        // Compressed step then negative branch
        do_update("j200", 2'd1, 32'h0000_0200, 1'b0, 32'h0, 0, 0);
        do_update("cincr", 2'd0, 32'h0, 1'b1, 32'h0, 0, 1);
        chk("cincr_c1", pc_data[1], 32'h0000_0202);
        chk("cincr_c0", pc_data[0], 32'h0000_0204);
        do_update("bneg", 2'd2, -32'sd16, 1'b0, 32'h0, 1, 0);
        chk("bneg_c1", pc_data[1], 32'h0000_01F2);

        // Misaligned jump
        do_update("j40", 2'd1, 32'h0000_0040, 1'b0, 32'h0, 0, 0);
        do_update("jmis", 2'd1, 32'h0000_1002, 1'b0, 32'h0000_8003, 0, 0);
        chk("jmis_pc", pc_data[0], 32'h0000_8000);
        chk("jmis_epc", epc[0], 32'h0000_0040);
        chk("jmis_tval", tval[0], 32'h0000_1002);
        chk("jmis_c1_pc", pc_data[1], 32'h0000_1002);

        // Trap op
        do_update("j300", 2'd1, 32'h0000_0300, 1'b0, 32'h0, 0, 0);
        do_update("trap", 2'd3, 32'h0, 1'b0, 32'h0000_8003, 0, 0);
        chk("trap_pc", pc_data[0], 32'h0000_8000);
        chk("trap_epc", epc[0], 32'h0000_0300);

        // Wrap-around, then four cycles of fetch back-pressure
        do_update("jtop", 2'd1, 32'hFFFF_FFFC, 1'b0, 32'h0, 0, 0);
        do_update("wrap", 2'd0, 32'h0, 1'b0, 32'h0, 0, 0);
        chk("wrap_pc", pc_data[0], 32'h0000_0000);
        do_update("bp", 2'd0, 32'h0, 1'b0, 32'h0, 4, 0);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) r_data = $urandom;
            else r_data = 32'($urandom_range(0, 63)) - 32'd32;
            do_update($sformatf("rnd%0d", i), r_op, r_data, 1'($urandom), $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset asserted in AWAIT with a command pending
        pc_ready = 1'b1;
        tick();
        pc_ready   = 1'b0;
        incr_valid = 1'b1;
        incr_op    = 2'd1;
        incr_data  = 32'h0000_5000;
        check_all("pre_rst", 1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        mdl_reset();
        check_all("rst_async", 1'b0, 1'b0);
        tick();
        check_all("rst_hold", 1'b0, 1'b0);
        rstn = 1'b1;
        incr_valid = 1'b0;
        tick();
        check_all("rst_issue", 1'b1, 1'b0);
        chk("rst_pc", pc_data[1], 32'h0000_0100);
        do_update("post_rst", 2'd0, 32'h0, 1'b0, 32'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
